// File: rtl/axi_mem_sched.sv
// axi_mem_sched: round-robin scheduler sharing one single-port memory between AXI AW and AR
// command streams. Optional macro AXI_MEM_SCHED_BACK2BACK_EN accepts the next command on the last beat.

module axi_addr #(
  parameter int ADDR_WIDTH = 12,
  parameter bit ALIGN_ADDR = 1'b1
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            burst,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  output logic [ADDR_WIDTH-1:0] next_addr
);
  localparam int CW = ADDR_WIDTH + 16;

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [CW-1:0]         span;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  assign incr      = ADDR_WIDTH'(1) << size;
  assign incr_addr = addr + incr;
  // Wrap window is (len+1) beats of 2^size bytes; a window of 2^ADDR_WIDTH truncates to all ones.
  assign span      = (CW'(len) + CW'(1)) << size;
  assign wrap_mask = span[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

  always_comb begin
    next_addr = incr_addr;
    case (burst)
      2'd0:    next_addr = addr;
      2'd2:    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = ALIGN_ADDR ? (incr_addr & ~(incr - ADDR_WIDTH'(1))) : incr_addr;
    endcase
  end
endmodule

module axi_mem_sched #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter bit ALIGN_ADDR = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_cmd_valid,
  output logic                  wr_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [1:0]            wr_burst,
  input  logic [2:0]            wr_size,
  input  logic [7:0]            wr_len,
  input  logic                  rd_cmd_valid,
  output logic                  rd_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [1:0]            rd_burst,
  input  logic [2:0]            rd_size,
  input  logic [7:0]            rd_len,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_last,
  output logic                  busy
);
  localparam int DATA_SIZE = $clog2(DATA_WIDTH / 8);

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic                  last_rd;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            burst_q;
  logic [2:0]            size_q;
  logic [7:0]            len_q;
  logic [7:0]            beat_q;
  logic [ADDR_WIDTH-1:0] next_addr;

  logic                  beat_fire, last_fire, accept_en;
  logic                  grant_wr, grant_rd, wr_take, rd_take;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [1:0]            cmd_burst, cmd_burst_eff;
  logic [2:0]            cmd_size, cmd_size_eff;
  logic [7:0]            cmd_len;
  logic                  cmd_wrap_ok;

  assign mem_valid = (state != IDLE);
  assign busy      = mem_valid;
  assign mem_we    = (state == WRITE);
  assign mem_addr  = addr_q;
  assign mem_last  = mem_valid && (beat_q == len_q);
  assign beat_fire = mem_valid && mem_ready;
  assign last_fire = beat_fire && mem_last;

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready; a beat transfers
  // where mem_valid && mem_ready. Readies depend on the valids, never the other way round.
`ifdef AXI_MEM_SCHED_BACK2BACK_EN
  assign accept_en = rst_n && ((state == IDLE) || last_fire);
`else
  assign accept_en = rst_n && (state == IDLE);
`endif

  // Ties go to whichever source was not served last.
  assign grant_wr     = wr_cmd_valid && (!rd_cmd_valid || last_rd);
  assign grant_rd     = rd_cmd_valid && (!wr_cmd_valid || !last_rd);
  assign wr_take      = accept_en && grant_wr;
  assign rd_take      = accept_en && grant_rd;
  assign wr_cmd_ready = wr_take;
  assign rd_cmd_ready = rd_take;

  always_comb begin
    cmd_addr      = wr_take ? wr_addr  : rd_addr;
    cmd_burst     = wr_take ? wr_burst : rd_burst;
    cmd_size      = wr_take ? wr_size  : rd_size;
    cmd_len       = wr_take ? wr_len   : rd_len;
    cmd_size_eff  = (cmd_size > 3'(DATA_SIZE)) ? 3'(DATA_SIZE) : cmd_size;
    cmd_wrap_ok   = (cmd_len == 8'd1) || (cmd_len == 8'd3) || (cmd_len == 8'd7) || (cmd_len == 8'd15);
    cmd_burst_eff = cmd_burst;
    if (cmd_burst == BURST_RSVD) begin
      cmd_burst_eff = BURST_INCR;
    end else if ((cmd_burst == BURST_WRAP) && !cmd_wrap_ok) begin
      cmd_burst_eff = BURST_INCR;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wr_take) begin
          state_nxt = WRITE;
        end else if (rd_take) begin
          state_nxt = READ;
        end
      end
      WRITE, READ: begin
        if (last_fire) begin
          state_nxt = IDLE;
          if (wr_take) begin
            state_nxt = WRITE;
          end else if (rd_take) begin
            state_nxt = READ;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rd <= 1'b1;
      addr_q  <= '0;
      burst_q <= BURST_FIXED;
      size_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
    end else if (wr_take || rd_take) begin
      last_rd <= rd_take;
      addr_q  <= cmd_addr;
      burst_q <= cmd_burst_eff;
      size_q  <= cmd_size_eff;
      len_q   <= cmd_len;
      beat_q  <= '0;
    end else if (beat_fire && !mem_last) begin
      addr_q  <= next_addr;
      beat_q  <= beat_q + 8'd1;
    end
  end

  axi_addr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ALIGN_ADDR (ALIGN_ADDR)
  ) u_axi_addr (
    .addr      (addr_q),
    .burst     (burst_q),
    .size      (size_q),
    .len       (len_q),
    .next_addr (next_addr)
  );

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_cmd_ready && rd_cmd_ready));
  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (mem_valid && !mem_ready) |=> (mem_valid && $stable(mem_addr) && $stable(mem_last) && $stable(mem_we)));
  a_beat_bound: assert property (@(posedge clk) disable iff (!rst_n)
    mem_valid |-> (beat_q <= len_q));
`endif
endmodule

// File: tb/tb_axi_mem_sched.sv
// Randomized and directed bench for axi_mem_sched against a burst-level reference model
// (arbitration, per-beat address lists and IDLE bubbles derived from the command rules).

module tb_axi_mem_sched;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DS    = 2;
  localparam bit ALIGN = 1'b1;
  localparam int W     = AW + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_cmd_valid = 1'b0, rd_cmd_valid = 1'b0;
  logic          wr_cmd_ready, rd_cmd_ready;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [1:0]    wr_burst = '0, rd_burst = '0;
  logic [2:0]    wr_size = '0, rd_size = '0;
  logic [7:0]    wr_len = '0, rd_len = '0;
  logic          mem_valid, mem_ready = 1'b1, mem_we, mem_last, busy;
  logic [AW-1:0] mem_addr;

  axi_mem_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ALIGN_ADDR(ALIGN)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .wr_addr(wr_addr),
    .wr_burst(wr_burst), .wr_size(wr_size), .wr_len(wr_len),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .rd_addr(rd_addr),
    .rd_burst(rd_burst), .rd_size(rd_size), .rd_len(rd_len),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_last(mem_last), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] obs_addr[$];
  bit            obs_we[$];
  int            obs_cyc[$];
  bit            lg_rd   = 1'b1;
  bit            mon_en  = 1'b0;
  bit            wr_fire = 1'b0, rd_fire = 1'b0;
  bit            rdy_mode = 1'b0;

  task automatic push_burst(input bit we, input int addr, input int burst, input int size, input int len);
    int sz, bt, incr, total, base, a;
    logic [W-1:0] ent;
    sz = (size > DS) ? DS : size;
    bt = burst;
    if (bt == 3) bt = 1;
    if (bt == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) bt = 1;
    incr  = 1 << sz;
    total = (len + 1) * incr;
    base  = (addr / total) * total;
    for (int i = 0; i <= len; i++) begin
      if (bt == 0)      a = addr;
      else if (bt == 2) a = base + ((addr - base + i * incr) % total);
      else if (i == 0)  a = addr;
      else              a = (ALIGN ? (addr / incr) * incr : addr) + i * incr;
      a = a % (1 << AW);
      ent = {we, (i == len), a[AW-1:0]};
      exp_q.push_back(ent);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    bit was_idle, popped_last, g_wr, g_rd;
    if (!mon_en) begin
      wr_fire = 1'b0;
      rd_fire = 1'b0;
    end else begin
      was_idle    = (exp_q.size() == 0);
      popped_last = 1'b0;
      if (was_idle) begin
        check_eq("idle", {mem_valid, busy, mem_last}, 3'b000);
      end else begin
        e = exp_q[0];
        check_eq("beat", {mem_valid, busy, mem_we, mem_last, mem_addr}, {2'b11, e});
        if (mem_ready) begin
          obs_addr.push_back(mem_addr);
          obs_we.push_back(mem_we);
          obs_cyc.push_back(cyc);
          popped_last = e[AW];
          void'(exp_q.pop_front());
        end
      end
`ifdef AXI_MEM_SCHED_BACK2BACK_EN
      g_wr = (was_idle || popped_last) && wr_cmd_valid && (!rd_cmd_valid || lg_rd);
      g_rd = (was_idle || popped_last) && rd_cmd_valid && (!wr_cmd_valid || !lg_rd);
`else
      g_wr = was_idle && wr_cmd_valid && (!rd_cmd_valid || lg_rd);
      g_rd = was_idle && rd_cmd_valid && (!wr_cmd_valid || !lg_rd);
`endif
      check_eq("cmd_ready", {wr_cmd_ready, rd_cmd_ready}, {g_wr, g_rd});
      if (g_wr) begin
        push_burst(1'b1, int'(wr_addr), int'(wr_burst), int'(wr_size), int'(wr_len));
        lg_rd = 1'b0;
      end
      if (g_rd) begin
        push_burst(1'b0, int'(rd_addr), int'(rd_burst), int'(rd_size), int'(rd_len));
        lg_rd = 1'b1;
      end
      wr_fire = wr_cmd_valid && wr_cmd_ready;
      rd_fire = rd_cmd_valid && rd_cmd_ready;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_mode) mem_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic send_wr(input logic [AW-1:0] a, input logic [1:0] b, input logic [2:0] s, input logic [7:0] l);
    int t = 0;
    wr_addr = a; wr_burst = b; wr_size = s; wr_len = l; wr_cmd_valid = 1'b1;
    do begin @(posedge clk); #1; t++; end while (!wr_fire && t < 300);
    check_eq("wr_accept_in_time", t < 300, 1);
    wr_cmd_valid = 1'b0;
  endtask

  task automatic send_rd(input logic [AW-1:0] a, input logic [1:0] b, input logic [2:0] s, input logic [7:0] l);
    int t = 0;
    rd_addr = a; rd_burst = b; rd_size = s; rd_len = l; rd_cmd_valid = 1'b1;
    do begin @(posedge clk); #1; t++; end while (!rd_fire && t < 300);
    check_eq("rd_accept_in_time", t < 300, 1);
    rd_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (exp_q.size() != 0 && t < 600) begin @(posedge clk); #1; t++; end
    check_eq("drain_in_time", t < 600, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_obs(input int n);
    int t = 0;
    while (obs_addr.size() < n && t < 300) begin @(posedge clk); #1; t++; end
    check_eq("beats_in_time", t < 300, 1);
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_we.delete(); obs_cyc.delete();
  endtask

  task automatic check_obs(input string tag, input int n, input int a0, input int a1,
                           input int a2, input int a3, input bit we);
    int ea[4];
    ea = '{a0, a1, a2, a3};
    check_eq({tag, "_count"}, obs_addr.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < obs_addr.size()) begin
        check_eq($sformatf("%s_addr%0d", tag, i), obs_addr[i], ea[i]);
        check_eq($sformatf("%s_we%0d", tag, i), obs_we[i], we);
      end
    end
  endtask

  task automatic apply_reset();
    mon_en = 1'b0;
    rst_n = 1'b0;
    wr_cmd_valid = 1'b1;
    rd_cmd_valid = 1'b1;
    #1;
    check_eq("rst_outputs", {mem_valid, mem_we, mem_last, busy, wr_cmd_ready, rd_cmd_ready, mem_addr}, 0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hold", {mem_valid, busy, wr_cmd_ready, rd_cmd_ready}, 0);
    wr_cmd_valid = 1'b0;
    rd_cmd_valid = 1'b0;
    exp_q.delete();
    lg_rd = 1'b1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int span;
    apply_reset();

    clear_obs();
    send_wr(12'h004, 2'd1, 3'd2, 8'd3);
    wait_idle();
    check_obs("incr_wr", 4, 'h004, 'h008, 'h00C, 'h010, 1'b1);
    check_eq("incr_wr_busy_after", busy, 0);

    clear_obs();
    send_rd(12'h038, 2'd2, 3'd2, 8'd3);
    wait_idle();
    check_obs("wrap_rd", 4, 'h038, 'h03C, 'h030, 'h034, 1'b0);

    clear_obs();
    send_wr(12'h003, 2'd1, 3'd2, 8'd2);
    wait_idle();
    check_obs("incr_unaligned", 3, 'h003, 'h004, 'h008, 0, 1'b1);

    clear_obs();
    send_rd(12'h100, 2'd0, 3'd2, 8'd2);
    wait_idle();
    check_obs("fixed_rd", 3, 'h100, 'h100, 'h100, 0, 1'b0);

    clear_obs();
    send_wr(12'hFFC, 2'd3, 3'd7, 8'd1);
    wait_idle();
    check_obs("clamp_wrapround", 2, 'hFFC, 'h000, 0, 0, 1'b1);

    // Contention from reset: grants must alternate, starting with the write side.
    apply_reset();
    clear_obs();
    fork
      for (int i = 0; i < 3; i++) send_wr(AW'(12'h200 + 4 * i), 2'd1, 3'd2, 8'd0);
      for (int i = 0; i < 3; i++) send_rd(AW'(12'h300 + 4 * i), 2'd1, 3'd2, 8'd0);
    join
    wait_idle();
    check_eq("alt_count", obs_we.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < obs_we.size()) check_eq($sformatf("alt_grant%0d", i), obs_we[i], (i % 2 == 0));
    end
    span = (obs_cyc.size() == 6) ? (obs_cyc[5] - obs_cyc[0]) : -1;
`ifdef AXI_MEM_SCHED_BACK2BACK_EN
    check_eq("alt_span_cycles", span, 5);
`else
    check_eq("alt_span_cycles", span, 10);
`endif

    // Stall on beat 2: presented beat must hold still.
    clear_obs();
    fork
      send_wr(12'h040, 2'd1, 3'd2, 8'd3);
      begin
        wait_obs(1);
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(posedge clk); #1;
          check_eq($sformatf("stall_hold%0d", i), {mem_valid, mem_last, mem_addr}, {2'b10, 12'h044});
        end
        mem_ready = 1'b1;
      end
    join
    wait_idle();
    check_obs("stall_wr", 4, 'h040, 'h044, 'h048, 'h04C, 1'b1);

    // Reset on beat 3 of a 16-beat burst: aborted and never replayed.
    clear_obs();
    send_wr(12'h000, 2'd1, 3'd2, 8'd15);
    wait_obs(2);
    #1;
    mon_en = 1'b0;
    rst_n = 1'b0;
    wr_cmd_valid = 1'b1;
    #1;
    check_eq("abort_outputs", {mem_valid, busy, mem_last, wr_cmd_ready}, 0);
    exp_q.delete();
    lg_rd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wr_cmd_valid = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("abort_no_replay", obs_addr.size(), 2);
    clear_obs();
    send_wr(12'h080, 2'd1, 3'd2, 8'd1);
    wait_idle();
    check_obs("after_abort", 2, 'h080, 'h084, 0, 0, 1'b1);

    // Random traffic, random memory back-pressure.
    rdy_mode = 1'b1;
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        send_wr(AW'($urandom_range(0, 4095)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                8'($urandom_range(0, 15)));
      end
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        send_rd(AW'($urandom_range(0, 4095)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                8'($urandom_range(0, 15)));
      end
    join
    rdy_mode = 1'b0;
    @(posedge clk); #2;
    mem_ready = 1'b1;
    wait_idle();
    check_eq("final_idle", {mem_valid, busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_mem_sched.md
# axi_mem_sched

Controller that shares one single-port memory between an AXI write-address stream and an AXI read-address stream. It arbitrates round-robin between the two command sources and sequences each accepted burst into per-beat memory addresses. Next-beat address generation (FIXED/INCR/WRAP, optional alignment) is delegated to an internal `axi_addr` instance. It sits between the AXI slave front-end (AW/AR decode) and the memory/data-path stage.

## Interface
- ADDR_WIDTH, 12, byte address width
- DATA_WIDTH, 32, memory data width in bits; DATA_SIZE = log2(DATA_WIDTH/8)
- ALIGN_ADDR, 1'b1, passed to `axi_addr`; realigns INCR beats after the first
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- wr_cmd_valid / wr_cmd_ready  in/out  1  write command handshake
- wr_addr, wr_burst, wr_size, wr_len  in  ADDR_WIDTH/2/3/8  AW fields
- rd_cmd_valid / rd_cmd_ready  in/out  1  read command handshake
- rd_addr, rd_burst, rd_size, rd_len  in  ADDR_WIDTH/2/3/8  AR fields
- mem_valid  out  1  beat request valid
- mem_ready  in  1  memory accepts beat
- mem_we  out  1  1 = write beat, 0 = read beat
- mem_addr  out  ADDR_WIDTH  byte address of current beat
- mem_last  out  1  current beat is final beat of burst
- busy  out  1  state != IDLE

## Operation
- States: IDLE, WRITE, READ.
- IDLE grant: only one valid -> that source; both valid -> source not granted last (last_grant resets to READ, so first tie goes to WRITE).
- Ready: the granted source's cmd_ready is 1 in IDLE, combinationally from its valid; the other ready is 0. Outside IDLE both readies are 0, except under the macro below.
- Capture on handshake: addr, burst, size, len; beat counter := 0; last_grant := granted source.
  - size > DATA_SIZE is clamped to DATA_SIZE.
  - burst RESERVED (3) is coerced to INCR.
  - WRAP with len not in {1,3,7,15} is coerced to INCR.
- Next state: WRITE (write granted) or READ (read granted).
- WRITE/READ:
  - mem_valid = 1; mem_we = (state == WRITE); mem_addr = address register; mem_last = (beat == len).
  - On mem_valid && mem_ready && !mem_last: address := `axi_addr`.next_addr; beat += 1.
  - On handshake with mem_last = 1: return to IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH. WRAP stays inside the (len+1)<<size window. FIXED repeats the captured address.
- len = 0 is a single beat; mem_last is 1 on the first beat.
- Outputs hold stable while mem_valid && !mem_ready.

## Timing
- Reset values: state IDLE, mem_valid 0, mem_we 0, mem_addr 0, mem_last 0, busy 0, wr/rd_cmd_ready 0 (valids ignored during reset), last_grant READ.
- Command accepted at edge N -> first beat presented in cycle N+1.
- Beats advance one per cycle at full mem_ready; a burst of len+1 beats occupies len+1 cycles minimum.
- Without the macro, one IDLE cycle separates bursts: the cycle after the last handshake has mem_valid 0.
- rst_n assertion mid-burst aborts it immediately (asynchronous). The partial burst is discarded and never replayed.
- No combinational path from mem_ready to any cmd_ready, except under the macro.

## Configuration
- AXI_MEM_SCHED_BACK2BACK_EN defined: the granted source's cmd_ready also asserts during the mem_last handshake cycle. Arbitration is the same as in IDLE. The new command loads on that edge and its first beat is presented the next cycle, with no IDLE bubble; this adds a mem_ready -> cmd_ready path.
- Undefined: commands are accepted only in IDLE.

## Test plan
- Write INCR addr 0x004, size 2, len 3 -> beats 0x004, 0x008, 0x00C, 0x010, mem_we 1, mem_last on the 4th beat, then busy 0.
- Read WRAP addr 0x038, size 2, len 3 -> beats 0x038, 0x03C, 0x030, 0x034, mem_we 0.
- Both valid every cycle after reset, len 0 each -> grants alternate W, R, W, R. Without the macro there is one bubble cycle between bursts; with it there is none.
- INCR addr 0x003, size 2, ALIGN_ADDR 1 -> beats 0x003, 0x004, 0x008; FIXED addr 0x100, len 2 -> 0x100 three times.
- mem_ready held low 5 cycles on beat 2 -> mem_addr/mem_last stable; rst_n pulsed low on beat 3 of a 16-beat burst -> mem_valid 0 at once, IDLE after release.
- size 7 on a 32-bit bus, burst 3, addr 0xFFC, len 1 -> size clamped to 2, treated as INCR, beats 0xFFC, 0x000.
